time_set_ctrl: RTL and testbench

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

---
 rtl/time_set_ctrl.sv | 124 ++++++++++++
 tb/tb_time_set_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// Clock time-keeper with RUN / SET_HOUR / SET_MIN edit FSM and BCD hh:mm:ss counters.
// Latency: all outputs registered, 1 cycle from input pulse; no backpressure (pulse inputs only).
module time_set_ctrl #(
    parameter logic [7:0] INIT_HOUR = 8'h00,
    parameter logic [7:0] INIT_MIN  = 8'h00
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tick_1hz,
    input  logic       i_mode_pulse,
    input  logic       i_inc_pulse,
    output logic [7:0] o_hour_bcd,
    output logic [7:0] o_min_bcd,
    output logic [7:0] o_sec_bcd,
    output logic [1:0] o_state,
    output logic       o_blink
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] hour_q, hour_d;
    logic [7:0] min_q, min_d;
    logic [7:0] sec_q, sec_d;
    logic       blink_q, blink_d;

    // Two-digit BCD increment that wraps to 00 after reaching maxv.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] maxv);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = v[7:4];
        units = v[3:0];
        if (v == maxv) begin
            return 8'h00;
        end else if (units == 4'd9) begin
            tens = tens + 4'd1;
            return {tens, 4'd0};
        end else begin
            units = units + 4'd1;
            return {tens, units};
        end
    endfunction

    always_comb begin
        state_d = state_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        blink_d = blink_q;
        case (state_q)
            ST_RUN: begin
                blink_d = 1'b0;
                if (i_tick_1hz) begin
                    sec_d = bcd_inc(sec_q, 8'h59);
                    if (sec_q == 8'h59) begin
                        min_d = bcd_inc(min_q, 8'h59);
                        if (min_q == 8'h59) begin
                            hour_d = bcd_inc(hour_q, 8'h23);
                        end
                    end
                end
                if (i_mode_pulse) begin
                    state_d = ST_SET_HOUR;
                    blink_d = 1'b1;
                end
            end
            ST_SET_HOUR: begin
                if (i_mode_pulse) begin
                    state_d = ST_SET_MIN;
                    blink_d = 1'b1;
                end else if (i_inc_pulse) begin
                    hour_d  = bcd_inc(hour_q, 8'h23);
                    blink_d = 1'b1;
                end else if (i_tick_1hz) begin
                    blink_d = ~blink_q;
                end
            end
            ST_SET_MIN: begin
                // Leaving the editor restarts the minute from a clean :00.
                if (i_mode_pulse) begin
                    state_d = ST_RUN;
                    sec_d   = 8'h00;
                    blink_d = 1'b0;
                end else if (i_inc_pulse) begin
                    min_d   = bcd_inc(min_q, 8'h59);
                    blink_d = 1'b1;
                end else if (i_tick_1hz) begin
                    blink_d = ~blink_q;
                end
            end
            default: begin
                state_d = ST_RUN;
                blink_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_RUN;
            hour_q  <= INIT_HOUR;
            min_q   <= INIT_MIN;
            sec_q   <= 8'h00;
            blink_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            blink_q <= blink_d;
        end
    end

    assign o_hour_bcd = hour_q;
    assign o_min_bcd  = min_q;
    assign o_sec_bcd  = sec_q;
    assign o_state    = state_q;
    assign o_blink    = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: vector table, corner sequences, random vs. integer model.
module tb_time_set_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_tick_1hz = 1'b0;
    logic       i_mode_pulse = 1'b0;
    logic       i_inc_pulse = 1'b0;
    logic [7:0] o_hour_bcd;
    logic [7:0] o_min_bcd;
    logic [7:0] o_sec_bcd;
    logic [1:0] o_state;
    logic       o_blink;

    int nvec = 0;
    int nerr = 0;

    // Reference model: plain integers for time, 0/1/2 for mode.
    int mh, mm, ms, mst, mbl;

    time_set_ctrl dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_tick_1hz   (i_tick_1hz),
        .i_mode_pulse (i_mode_pulse),
        .i_inc_pulse  (i_inc_pulse),
        .o_hour_bcd   (o_hour_bcd),
        .o_min_bcd    (o_min_bcd),
        .o_sec_bcd    (o_sec_bcd),
        .o_state      (o_state),
        .o_blink      (o_blink)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic       mode;
        logic       inc;
        logic       tick;
        logic [7:0] h;
        logic [7:0] m;
        logic [7:0] s;
        logic [1:0] st;
        logic       bl;
    } vec_t;

    vec_t tbl[14];

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'((v / 10) % 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    task automatic model_reset();
        mh = 0; mm = 0; ms = 0; mst = 0; mbl = 0;
    endtask

    task automatic model_step(input logic m, input logic n, input logic t);
        if (mst == 0) begin
            if (t) begin
                ms = ms + 1;
                if (ms == 60) begin
                    ms = 0;
                    mm = mm + 1;
                    if (mm == 60) begin
                        mm = 0;
                        mh = (mh + 1) % 24;
                    end
                end
            end
            mbl = m ? 1 : 0;
            if (m) mst = 1;
        end else if (m) begin
            if (mst == 1) begin
                mst = 2; mbl = 1;
            end else begin
                mst = 0; ms = 0; mbl = 0;
            end
        end else if (n) begin
            if (mst == 1) mh = (mh + 1) % 24;
            else mm = (mm + 1) % 60;
            mbl = 1;
        end else if (t) begin
            mbl = 1 - mbl;
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [7:0] h, input logic [7:0] m,
                           input logic [7:0] s, input logic [1:0] st, input logic bl);
        chk({name, ".hour"},  o_hour_bcd, h);
        chk({name, ".min"},   o_min_bcd,  m);
        chk({name, ".sec"},   o_sec_bcd,  s);
        chk({name, ".state"}, {6'd0, o_state}, {6'd0, st});
        chk({name, ".blink"}, {7'd0, o_blink}, {7'd0, bl});
    endtask

    task automatic chk_model(input string name);
        chk_out(name, to_bcd(mh), to_bcd(mm), to_bcd(ms), 2'(mst), mbl[0]);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic m, input logic n, input logic t);
        i_mode_pulse = m;
        i_inc_pulse  = n;
        i_tick_1hz   = t;
        @(posedge i_clk);
        model_step(m, n, t);
        @(negedge i_clk);
        i_mode_pulse = 1'b0;
        i_inc_pulse  = 1'b0;
        i_tick_1hz   = 1'b0;
    endtask

    // Reset is raised and released between edges; outputs must already be at init values.
    task automatic do_reset(input string name);
        i_rst = 1'b1;
        #1;
        chk_out(name, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0);
        #2;
        i_rst = 1'b0;
        model_reset();
        @(negedge i_clk);
    endtask

    initial begin
        logic rm, ri, rt;

        tbl[0]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h01, 2'd0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h01, 2'd0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h01, 2'd1, 1'b1};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 8'h01, 2'd1, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 8'h01, 8'h00, 8'h01, 2'd1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 8'h02, 8'h00, 8'h01, 2'd1, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 8'h02, 8'h00, 8'h01, 2'd1, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 8'h02, 8'h00, 8'h01, 2'd2, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 8'h02, 8'h01, 8'h01, 2'd2, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 8'h02, 8'h01, 8'h00, 2'd0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 8'h02, 8'h01, 8'h01, 2'd0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 8'h02, 8'h01, 8'h02, 2'd1, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 8'h02, 8'h01, 8'h02, 2'd2, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 8'h02, 8'h01, 8'h00, 2'd0, 1'b0};

        model_reset();
        @(negedge i_clk);
        do_reset("por");

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].mode, tbl[i].inc, tbl[i].tick);
            chk_out($sformatf("vec%0d", i), tbl[i].h, tbl[i].m, tbl[i].s, tbl[i].st, tbl[i].bl);
        end

        // Sixty seconds from reset.
        do_reset("rst_a");
        repeat (60) step(1'b0, 1'b0, 1'b1);
        chk_out("ticks60", 8'h00, 8'h01, 8'h00, 2'd0, 1'b0);

        // Set 23:59, then roll the whole clock over.
        do_reset("rst_b");
        step(1'b1, 1'b0, 1'b0);
        repeat (23) step(1'b0, 1'b1, 1'b0);
        chk("roll_set_h", o_hour_bcd, 8'h23);
        step(1'b1, 1'b0, 1'b0);
        repeat (59) step(1'b0, 1'b1, 1'b0);
        chk("roll_set_m", o_min_bcd, 8'h59);
        step(1'b1, 1'b0, 1'b0);
        chk_out("roll_run", 8'h23, 8'h59, 8'h00, 2'd0, 1'b0);
        repeat (59) step(1'b0, 1'b0, 1'b1);
        chk_out("roll_2359", 8'h23, 8'h59, 8'h59, 2'd0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk_out("roll_0000", 8'h00, 8'h00, 8'h00, 2'd0, 1'b0);

        // Set-mode wraps do not carry into the neighbouring field.
        do_reset("rst_c");
        step(1'b1, 1'b0, 1'b0);
        repeat (24) step(1'b0, 1'b1, 1'b0);
        chk_out("sh_wrap", 8'h00, 8'h00, 8'h00, 2'd1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (60) step(1'b0, 1'b1, 1'b0);
        chk_out("sm_wrap", 8'h01, 8'h00, 8'h00, 2'd2, 1'b1);
        step(1'b1, 1'b0, 1'b0);

        // Mode beats inc; ticks freeze time and toggle blink.
        do_reset("rst_d");
        repeat (5) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        chk_out("modeinc", 8'h00, 8'h00, 8'h05, 2'd1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk_out("blink_t1", 8'h00, 8'h00, 8'h05, 2'd1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk_out("blink_t2", 8'h00, 8'h00, 8'h05, 2'd1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk_out("blink_t3", 8'h00, 8'h00, 8'h05, 2'd1, 1'b0);

        // Asynchronous reset in the middle of an edit.
        do_reset("rst_e");
        step(1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (7) step(1'b0, 1'b1, 1'b0);
        chk_out("pre_rst", 8'h03, 8'h07, 8'h00, 2'd2, 1'b1);
        do_reset("midset_rst");
        step(1'b0, 1'b0, 1'b1);
        chk_out("post_rst_tick", 8'h00, 8'h00, 8'h01, 2'd0, 1'b0);

        // Mode and tick together in RUN: the second still counts, with carry.
        do_reset("rst_f");
        repeat (59) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk_out("modetick", 8'h00, 8'h01, 8'h00, 2'd1, 1'b1);

        // Random traffic against the integer model.
        do_reset("rst_rand");
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset("rand_rst");
            end else begin
                rm = ($urandom_range(0, 7) == 0);
                ri = ($urandom_range(0, 2) == 0);
                rt = ($urandom_range(0, 1) == 1);
                step(rm, ri, rt);
                chk_model($sformatf("rand%0d", i));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
